clk_bus_master: RTL and testbench

//  Initiator side of the digital-clock CPU register bus. Polls the seconds-clock RUN_TIME

---
 rtl/clk_bus_pkg.sv | 32 +++
 rtl/clk_bus_master_hms_conv.sv | 121 ++++++++++++
 rtl/clk_bus_master.sv | 188 ++++++++++++++++++
 tb/tb_clk_bus_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_bus_pkg.sv
// Shared constants and state encodings for the clock bus master.
//   ADDR_RUN_TIME / ADDR_CLR : responder register addresses
//   SEC_PER_*                : time-conversion constants (17-bit)
//   bus_state_e              : bus FSM states (top level)
//   conv_state_e             : seconds-to-BCD converter states
package clk_bus_pkg;

  localparam logic [7:0]  ADDR_RUN_TIME = 8'h04;
  localparam logic [7:0]  ADDR_CLR      = 8'h08;

  localparam logic [16:0] SEC_PER_DAY   = 17'd86400;
  localparam logic [16:0] SEC_PER_HOUR  = 17'd3600;
  localparam logic [16:0] SEC_PER_MIN   = 17'd60;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_GAP    = 3'd2,
    ST_RD     = 3'd3,
    ST_CAP    = 3'd4,
    ST_CONV   = 3'd5,
    ST_UPDATE = 3'd6
  } bus_state_e;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_DIV_H = 2'd1,
    CV_DIV_M = 2'd2,
    CV_TENS  = 2'd3
  } conv_state_e;

endpackage

// File: rtl/clk_bus_master_hms_conv.sv
// Seconds-of-day to BCD HH:MM:SS converter using repeated subtraction.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   start_i, sec_i[16:0]  start pulse and seconds value (taken in idle only)
//   done_o                1-cycle pulse; hh/mm/ss_bcd_o are valid in that cycle
//   hh/mm/ss_bcd_o        {tens,units} BCD results, held until the next start
//
// state    | meaning
// CV_IDLE  | waiting for start
// CV_DIV_H | subtract 3600 per cycle, count hours
// CV_DIV_M | subtract 60 per cycle, count minutes; remainder becomes seconds
// CV_TENS  | split h/m/s into tens and units in parallel, done when all < 10
module hms_conv
  import clk_bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [16:0] sec_i,
  output logic        done_o,
  output logic [7:0]  hh_bcd_o,
  output logic [7:0]  mm_bcd_o,
  output logic [7:0]  ss_bcd_o
);

  conv_state_e state_q, state_d;
  logic [16:0] rem_q, rem_d;
  logic [5:0]  h_q, h_d, m_q, m_d, s_q, s_d;
  logic [3:0]  ht_q, ht_d, mt_q, mt_d, st_q, st_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    ht_d    = ht_q;
    mt_d    = mt_q;
    st_d    = st_q;
    done_o  = 1'b0;
    case (state_q)
      CV_IDLE: begin
        if (start_i) begin
          rem_d   = sec_i;
          h_d     = '0;
          m_d     = '0;
          s_d     = '0;
          ht_d    = '0;
          mt_d    = '0;
          st_d    = '0;
          state_d = CV_DIV_H;
        end
      end
      CV_DIV_H: begin
        if (rem_q >= SEC_PER_HOUR) begin
          rem_d = rem_q - SEC_PER_HOUR;
          h_d   = h_q + 6'd1;
        end else begin
          state_d = CV_DIV_M;
        end
      end
      CV_DIV_M: begin
        if (rem_q >= SEC_PER_MIN) begin
          rem_d = rem_q - SEC_PER_MIN;
          m_d   = m_q + 6'd1;
        end else begin
          // remainder is below 60 here, so it fits the seconds register
          s_d     = rem_q[5:0];
          state_d = CV_TENS;
        end
      end
      CV_TENS: begin
        if (h_q >= 6'd10) begin
          h_d  = h_q - 6'd10;
          ht_d = ht_q + 4'd1;
        end
        if (m_q >= 6'd10) begin
          m_d  = m_q - 6'd10;
          mt_d = mt_q + 4'd1;
        end
        if (s_q >= 6'd10) begin
          s_d  = s_q - 6'd10;
          st_d = st_q + 4'd1;
        end
        if ((h_q < 6'd10) && (m_q < 6'd10) && (s_q < 6'd10)) begin
          done_o  = 1'b1;
          state_d = CV_IDLE;
        end
      end
      default: state_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= CV_IDLE;
      rem_q   <= '0;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      ht_q    <= '0;
      mt_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ht_q    <= ht_d;
      mt_q    <= mt_d;
      st_q    <= st_d;
    end
  end

  // units registers are below 10 whenever done_o is high
  assign hh_bcd_o = {ht_q, h_q[3:0]};
  assign mm_bcd_o = {mt_q, m_q[3:0]};
  assign ss_bcd_o = {st_q, s_q[3:0]};

endmodule

// File: rtl/clk_bus_master.sv
// Bus initiator for the seconds clock: polls RUN_TIME, converts it to BCD
// HH:MM:SS for the display, and issues CLR writes on user request.
// Optional feature macro: TIME_ERR_EN (adds err_o, flags out-of-range reads).
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   clr_req_i               1-cycle clear request
//   wr_o, waddr_o, wdata_o  bus write strobe / address / data
//   rd_o, raddr_o, rdata_i  bus read strobe / address / data (cycle after rd)
//   hh/mm/ss_bcd_o          displayed time, BCD
//   upd_o                   1-cycle pulse when the display registers change
//   busy_o                  FSM not idle
//   err_o                   (TIME_ERR_EN only) last read was >= one day
//
// state     | meaning
// ST_IDLE   | poll counter running; clear request beats a due read
// ST_WR     | CLR write on the bus
// ST_GAP    | bus idle one cycle so the responder sees the clr settle
// ST_RD     | RUN_TIME read on the bus, poll counter restarts
// ST_CAP    | rdata valid; start conversion (or flag error)
// ST_CONV   | waiting for the converter
// ST_UPDATE | display registers loaded, upd pulse
module clk_bus_master
  import clk_bus_pkg::*;
#(
  parameter int ADDRWIDTH   = 4,
  parameter int POLL_CYCLES = 5_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_req_i,
  output logic                 wr_o,
  output logic [ADDRWIDTH-1:0] waddr_o,
  output logic [31:0]          wdata_o,
  output logic                 rd_o,
  output logic [ADDRWIDTH-1:0] raddr_o,
  input  logic [31:0]          rdata_i,
  output logic [7:0]           hh_bcd_o,
  output logic [7:0]           mm_bcd_o,
  output logic [7:0]           ss_bcd_o,
  output logic                 upd_o,
  output logic                 busy_o
`ifdef TIME_ERR_EN
  ,
  output logic                 err_o
`endif
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

  bus_state_e    state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          rd_due_q, rd_due_d;
  logic          clr_pend_q, clr_pend_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic          expire;
  logic          clr_now;
  logic          conv_start;
  logic          conv_done;
  logic [7:0]    conv_hh, conv_mm, conv_ss;
`ifdef TIME_ERR_EN
  logic          err_q, err_d;
`else
  logic          unused_rdata_hi;
  assign unused_rdata_hi = |rdata_i[31:17];
`endif

  assign expire  = (state_q == ST_IDLE) && (poll_q == POLL_LAST);
  // a request arriving in the same cycle as a decision still wins
  assign clr_now = clr_pend_q | clr_req_i;

  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    rd_due_d   = rd_due_q;
    clr_pend_d = clr_now;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    conv_start = 1'b0;
`ifdef TIME_ERR_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (expire) begin
          poll_d   = '0;
          rd_due_d = 1'b1;
        end else begin
          poll_d = poll_q + PW'(1);
        end
        if (clr_now) begin
          clr_pend_d = 1'b0;
          state_d    = ST_WR;
        end else if (rd_due_q || expire) begin
          state_d = ST_RD;
        end
      end
      ST_WR:  state_d = ST_GAP;
      ST_GAP: begin
        rd_due_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_RD: begin
        rd_due_d = 1'b0;
        poll_d   = '0;
        state_d  = ST_CAP;
      end
      ST_CAP: begin
`ifdef TIME_ERR_EN
        if (rdata_i >= {15'd0, SEC_PER_DAY}) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d      = 1'b0;
          conv_start = 1'b1;
          state_d    = ST_CONV;
        end
`else
        conv_start = 1'b1;
        state_d    = ST_CONV;
`endif
      end
      ST_CONV: begin
        if (conv_done) begin
          hh_d    = conv_hh;
          mm_d    = conv_mm;
          ss_d    = conv_ss;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      poll_q     <= '0;
      rd_due_q   <= 1'b0;
      clr_pend_q <= 1'b0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
`ifdef TIME_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      rd_due_q   <= rd_due_d;
      clr_pend_q <= clr_pend_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
`ifdef TIME_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  hms_conv u_hms_conv (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (conv_start),
    .sec_i    (rdata_i[16:0]),
    .done_o   (conv_done),
    .hh_bcd_o (conv_hh),
    .mm_bcd_o (conv_mm),
    .ss_bcd_o (conv_ss)
  );

  assign wr_o     = (state_q == ST_WR);
  assign rd_o     = (state_q == ST_RD);
  assign waddr_o  = wr_o ? ADDRWIDTH'(ADDR_CLR) : '0;
  assign wdata_o  = wr_o ? 32'h1 : 32'h0;
  assign raddr_o  = rd_o ? ADDRWIDTH'(ADDR_RUN_TIME) : '0;
  assign upd_o    = (state_q == ST_UPDATE);
  assign busy_o   = (state_q != ST_IDLE);
  assign hh_bcd_o = hh_q;
  assign mm_bcd_o = mm_q;
  assign ss_bcd_o = ss_q;
`ifdef TIME_ERR_EN
  assign err_o    = err_q;
`endif

endmodule

// File: tb/tb_clk_bus_master.sv
module tb_clk_bus_master;

  localparam int AW   = 4;
  localparam int POLL = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic [31:0]   rdata = '0;
  logic          wr, rd, upd, busy;
  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata;
  logic [7:0]    hh, mm, ss;
`ifdef TIME_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  clk_bus_master #(.ADDRWIDTH(AW), .POLL_CYCLES(POLL)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .clr_req_i (clr_req),
    .wr_o      (wr),
    .waddr_o   (waddr),
    .wdata_o   (wdata),
    .rd_o      (rd),
    .raddr_o   (raddr),
    .rdata_i   (rdata),
    .hh_bcd_o  (hh),
    .mm_bcd_o  (mm),
    .ss_bcd_o  (ss),
    .upd_o     (upd),
    .busy_o    (busy)
`ifdef TIME_ERR_EN
    ,
    .err_o     (err)
`endif
  );

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    bit         err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_vals[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          idle_cnt = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          txn_done = 0;
  bit          pend_model = 0;
  bit          outstanding = 0;
  bit          wr_since_rd = 0;
  bit          rd_prev = 0;
  bit          wr_prev = 0;
  bit          chk_upd_low = 0;
  logic [23:0] last_disp = '0;
  exp_t        e;
  logic [31:0] v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: seconds-of-day split by plain division, decimal digits as BCD.
  function automatic exp_t model(input logic [31:0] val);
    exp_t        r;
    int unsigned t, h, m, s;
    r.err = 0;
    r.hh  = '0;
    r.mm  = '0;
    r.ss  = '0;
`ifdef TIME_ERR_EN
    if (val >= 32'd86400) begin
      r.err = 1;
      return r;
    end
`endif
    t = int'(val[16:0]);
    h = t / 3600;
    m = (t % 3600) / 60;
    s = t % 60;
    r.hh = {4'(h / 10), 4'(h % 10)};
    r.mm = {4'(m / 10), 4'(m % 10)};
    r.ss = {4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  function automatic logic [31:0] gen();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 6)      return 32'($urandom_range(0, 86399));
    else if (k < 8) return 32'($urandom_range(86400, 131071));
    else            return $urandom;
  endfunction

  // reset flushes everything in flight
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
      pend_model  = 0;
      idle_cnt    = 0;
      wr_since_rd = 0;
      rd_prev     = 0;
      wr_prev     = 0;
      chk_upd_low = 0;
      last_disp   = '0;
    end
  end

  // responder model + scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (chk_upd_low) begin
        chk("upd_width", upd, 0);
        chk_upd_low = 0;
      end
      if (wr || rd) chk("wr_rd_exclusive", wr & rd, 0);
      if (busy && !wr) chk("waddr_wdata_idle", {28'd0, waddr} | wdata, 0);
      if (busy && !rd) chk("raddr_idle", raddr, 0);
      if (wr) begin
        chk("waddr", waddr, 8);
        chk("wdata", wdata, 1);
        chk("wr_expected", pend_model, 1);
        chk("wr_width", wr_prev, 0);
        chk("wr_not_mid_txn", outstanding, 0);
        pend_model  = 0;
        wr_cyc      = cyc;
        wr_since_rd = 1;
      end
      if (upd) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL upd_unexpected: got upd with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("upd_for_err_read", e.err, 0);
          chk("hh_bcd", hh, e.hh);
          chk("mm_bcd", mm, e.mm);
          chk("ss_bcd", ss, e.ss);
          chk("rd_to_upd_le_93", (cyc - rd_cyc) <= 93, 1);
`ifdef TIME_ERR_EN
          chk("err_cleared", err, 0);
`endif
          last_disp = {hh, mm, ss};
        end
        outstanding = 0;
        txn_done++;
        chk_upd_low = 1;
      end else if (outstanding && !busy) begin
        // transaction ended without an update
        e = exp_q.pop_front();
        chk("upd_missing", e.err, 1);
`ifdef TIME_ERR_EN
        chk("err_set", err, 1);
`endif
        chk("display_held", {hh, mm, ss}, last_disp);
        outstanding = 0;
        txn_done++;
      end
      if (rd) begin
        chk("raddr", raddr, 4);
        chk("rd_width", rd_prev, 0);
        if (wr_since_rd) chk("wr_gap_rd", (cyc - wr_cyc) inside {[2:3]}, 1);
        else             chk("poll_interval", idle_cnt, POLL);
        idle_cnt    = 0;
        wr_since_rd = 0;
        v = (rd_vals.size() != 0) ? rd_vals.pop_front() : gen();
        rdata = v;
        exp_q.push_back(model(v));
        outstanding = 1;
        rd_cyc      = cyc;
      end else if (!busy) begin
        idle_cnt++;
      end
      rd_prev = rd;
      wr_prev = wr;
    end
  end

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL timeout %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic wait_quiet();
    int i = 0;
    while (!(rd_vals.size() == 0 && !outstanding && !pend_model && !busy) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 2000) timeout("quiet");
  endtask

  task automatic wait_rd();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!rd && i < 1000);
    if (!rd) timeout("rd");
  endtask

  task automatic pulse_clr();
    clr_req    = 1'b1;
    pend_model = 1;
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {hh, mm, ss, wr, rd, upd, busy}, 0);
    chk({name, "_bus"}, {28'd0, waddr} | {28'd0, raddr} | wdata, 0);
`ifdef TIME_ERR_EN
    chk({name, "_err"}, err, 0);
`endif
  endtask

  initial begin
    int i;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_state");

    // first poll returns 3661 -> 01:01:01
    rd_vals.push_back(32'd3661);
    wait_quiet();
    // 86399 -> 23:59:59 within the latency bound
    rd_vals.push_back(32'd86399);
    wait_quiet();

    // clear in idle: write, gap, read of 0
    rd_vals.push_back(32'd0);
    @(posedge clk);
    #1 pulse_clr();
    wait_quiet();

    // clear on the exact cycle of poll expiry: write must come first
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (idle_cnt != POLL - 1 && i < 1000);
    if (idle_cnt != POLL - 1) timeout("expiry");
    #1 pulse_clr();
    i = 0;
    while (!(wr || rd) && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("wr_before_rd", {wr, rd}, 2'b10);
    wait_quiet();

    // two requests during a conversion collapse to one write
    rd_vals.push_back(32'd50000);
    wait_rd();
    @(posedge clk);
    #1 pulse_clr();
    @(posedge clk);
    #1 pulse_clr();
    wait_quiet();

    // reset in the middle of DIV_M
    rd_vals.push_back(32'd86399);
    wait_rd();
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    wait_quiet();

    // out-of-day value, then a valid one
    rd_vals.push_back(32'd90000);
    wait_quiet();
    rd_vals.push_back(32'd3661);
    wait_quiet();

    // randomized reads from the responder, occasional clears mid-conversion
    for (int k = 0; k < 25; k++) begin
      wait_rd();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 pulse_clr();
      end
      wait_quiet();
    end

    wait_quiet();
    chk("write_left_pending", pend_model, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
